// File: rtl/npe_result_writer.sv
// -----------------------------------------------------------------------------
// npe_result_writer
//
// Consumer end of the npe result interface. Each result vector (DATA_COPIES
// lanes of 2*DATA_WIDTH bits) arrives on a valid strobe with no backpressure.
// It is optionally saturated to signed DATA_WIDTH lanes, buffered in a small
// FIFO, and then serialised into BEAT_WIDTH-bit write beats at consecutive
// addresses of the output buffer. The controller programs each layer with
// start/base/count.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start                one-cycle job start (honoured in IDLE only)
//   i_base_addr            first beat address of the job
//   i_result_num           number of result vectors in the job
//   i_sat_mode             1: saturate lanes to signed DATA_WIDTH
//   i_npe_result(_vld)     result vector and its strobe (no ready)
//   o_wr_data/addr/vld     write beat towards the output buffer
//   i_wr_rdy               sink accepts the beat
//   o_busy                 high while a job is running
//   o_done                 one-cycle completion pulse
//   o_overflow             sticky: a vector was dropped on a full FIFO
//
// Write port handshake: a beat transfers on a cycle where o_wr_vld and
// i_wr_rdy are both high. o_wr_vld, once raised, stays high until the beat
// transfers, and o_wr_data/o_wr_addr hold stable while i_wr_rdy is low.
// -----------------------------------------------------------------------------
module npe_result_writer #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32,
    parameter int BEAT_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_start,
    input  logic [ADDR_WIDTH-1:0]               i_base_addr,
    input  logic [CNT_WIDTH-1:0]                i_result_num,
    input  logic                                i_sat_mode,
    input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_npe_result,
    input  logic                                i_npe_result_vld,
    output logic [BEAT_WIDTH-1:0]               o_wr_data,
    output logic [ADDR_WIDTH-1:0]               o_wr_addr,
    output logic                                o_wr_vld,
    input  logic                                i_wr_rdy,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_overflow
);

    localparam int LANE_W  = 2 * DATA_WIDTH;
    localparam int RAW_W   = DATA_COPIES * LANE_W;
    localparam int SAT_W   = DATA_COPIES * DATA_WIDTH;
    localparam int P_RAW   = RAW_W / BEAT_WIDTH;
    localparam int P_SAT   = SAT_W / BEAT_WIDTH;
    localparam int BI_W    = (P_RAW > 1) ? $clog2(P_RAW) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FILL_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Job FSM state; kept as a plainly named register so checkers can bind to it.
    state_t                 state;
    logic                   busy_q;
    logic                   done_q;

    // Job parameters latched on start
    logic [CNT_WIDTH-1:0]   num_q;
    logic                   sat_q;

    // Progress counters
    logic [CNT_WIDTH-1:0]   acc_cnt;   // vectors pushed into the FIFO
    logic [CNT_WIDTH-1:0]   wr_cnt;    // vectors fully written out
    logic [BI_W-1:0]        beat_idx;  // beat of the head vector on the port
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic                   ovf_q;

    // Vector FIFO
    logic [RAW_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [FILL_W-1:0]      fill;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic [BI_W-1:0]        beat_last;
    logic                   wr_hs;
    logic                   pop;
    logic                   want;
    logic                   push;
    logic                   drop;
    logic                   start_go;

    logic [LANE_W-1:0]      lane;
    logic [DATA_WIDTH:0]    lane_top;
    logic [DATA_WIDTH-1:0]  lane_sat;
    logic [SAT_W-1:0]       sat_vec;
    logic [RAW_W-1:0]       store_vec;
    logic [RAW_W-1:0]       head_vec;
    logic [BEAT_WIDTH-1:0]  beat_data;

    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == FILL_W'(FIFO_DEPTH));
    assign beat_last  = sat_q ? BI_W'(P_SAT - 1) : BI_W'(P_RAW - 1);
    assign wr_hs      = !fifo_empty && i_wr_rdy;
    // The head vector leaves the FIFO when its last beat transfers.
    assign pop        = wr_hs && (beat_idx == beat_last);
    assign want       = (state == ST_RUN) && i_npe_result_vld && (acc_cnt < num_q);
    // A full FIFO still accepts when the head is popping in the same cycle.
    assign push       = want && (!fifo_full || pop);
    assign drop       = want && fifo_full && !pop;
    assign start_go   = (state == ST_IDLE) && i_start;

    // Per-lane saturation: a lane fits in DATA_WIDTH signed bits exactly
    // when its top DATA_WIDTH+1 bits are all equal; otherwise clamp by sign.
    always_comb begin
        lane     = '0;
        lane_top = '0;
        lane_sat = '0;
        sat_vec  = '0;
        for (int k = 0; k < DATA_COPIES; k++) begin
            lane     = i_npe_result[k*LANE_W +: LANE_W];
            lane_top = lane[LANE_W-1:DATA_WIDTH-1];
            if ((&lane_top) || !(|lane_top)) begin
                lane_sat = lane[DATA_WIDTH-1:0];
            end else if (lane[LANE_W-1]) begin
                lane_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                lane_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
            sat_vec[k*DATA_WIDTH +: DATA_WIDTH] = lane_sat;
        end
    end

    // Saturated vectors occupy the low SAT_W bits of a FIFO entry.
    assign store_vec = sat_q ? {{(RAW_W-SAT_W){1'b0}}, sat_vec} : i_npe_result;

    assign head_vec = fifo_mem[rd_ptr];

    always_comb begin
        beat_data = '0;
        for (int b = 0; b < P_RAW; b++) begin
            if (beat_idx == BI_W'(b)) begin
                beat_data = head_vec[b*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    assign o_wr_vld   = !fifo_empty;
    // Empty FIFO entries are never reset, so the data bus is forced to 0.
    assign o_wr_data  = fifo_empty ? '0 : beat_data;
    assign o_wr_addr  = wr_addr_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overflow = ovf_q;

    // Job FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_result_num == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Leaving on the final pop makes o_done appear in the
                    // cycle right after the last beat transfers.
                    if (pop && (wr_cnt == num_q - CNT_WIDTH'(1))) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: job parameters, counters, FIFO pointers, write address
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_q     <= '0;
            sat_q     <= 1'b0;
            acc_cnt   <= '0;
            wr_cnt    <= '0;
            beat_idx  <= '0;
            wr_addr_q <= '0;
            ovf_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
        end else if (start_go) begin
            num_q     <= i_result_num;
            sat_q     <= i_sat_mode;
            acc_cnt   <= '0;
            wr_cnt    <= '0;
            beat_idx  <= '0;
            wr_addr_q <= i_base_addr;
            ovf_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                acc_cnt <= acc_cnt + CNT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
            if (wr_hs) begin
                wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                beat_idx  <= pop ? '0 : beat_idx + BI_W'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FIFO storage (no reset needed: occupancy is tracked by fill)
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= store_vec;
        end
    end

endmodule

// File: tb/tb_npe_result_writer.sv
// -----------------------------------------------------------------------------
// Testbench for npe_result_writer.
// Stimulus is driven 1 ns after the rising edge; a reference model and a
// beat monitor both sample on the falling edge. The model works at job level
// (vector queue occupancy, beats per vector, address = base + beats so far)
// and pushes every expected beat into exp_q when it predicts acceptance.
// -----------------------------------------------------------------------------
module tb_npe_result_writer;

    localparam int DW    = 8;
    localparam int DC    = 32;
    localparam int BW    = 128;
    localparam int AW    = 16;
    localparam int FD    = 4;
    localparam int CW    = 16;
    localparam int RAW_W = DC * 2 * DW;
    localparam int P_RAW = RAW_W / BW;

    // ---------------- clock / reset / DUT ----------------
    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     base  = '0;
    logic [CW-1:0]     num   = '0;
    logic              sat   = 1'b0;
    logic [RAW_W-1:0]  vec   = '0;
    logic              vld   = 1'b0;
    logic              rdy   = 1'b0;
    logic [BW-1:0]     o_wr_data;
    logic [AW-1:0]     o_wr_addr;
    logic              o_wr_vld;
    logic              o_busy;
    logic              o_done;
    logic              o_overflow;

    always #5 clk = ~clk;

    npe_result_writer #(
        .DATA_WIDTH (DW),
        .DATA_COPIES(DC),
        .BEAT_WIDTH (BW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_base_addr     (base),
        .i_result_num    (num),
        .i_sat_mode      (sat),
        .i_npe_result    (vec),
        .i_npe_result_vld(vld),
        .o_wr_data       (o_wr_data),
        .o_wr_addr       (o_wr_addr),
        .o_wr_vld        (o_wr_vld),
        .i_wr_rdy        (rdy),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_overflow      (o_overflow)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+BW-1:0] exp_q[$];
    logic [BW-1:0]    cap_data_q[$];
    logic [AW-1:0]    cap_addr_q[$];
    int               done_count  = 0;
    int               done_cyc    = 0;
    int               last_hs_cyc = 0;
    int               start_cyc   = 0;

    task automatic check(input string name, input logic [RAW_W-1:0] act,
                         input logic [RAW_W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [RAW_W-1:0] stored_form(input logic [RAW_W-1:0] v,
                                                     input bit s);
        logic [RAW_W-1:0]   r;
        logic signed [15:0] l;
        int                 x;
        if (!s) return v;
        r = '0;
        for (int k = 0; k < DC; k++) begin
            l = v[k*16 +: 16];
            x = l;
            if (x > 127)  x = 127;
            if (x < -128) x = -128;
            r[k*8 +: 8] = x[7:0];
        end
        return r;
    endfunction

    int            m_state = 0;   // 0 idle, 1 run, 2 done
    int            m_num   = 0;
    bit            m_sat   = 0;
    logic [AW-1:0] m_base  = '0;
    int            m_acc   = 0;
    int            m_wr    = 0;
    int            m_occ   = 0;
    int            m_hb    = 0;
    bit            m_ovf   = 0;
    int            m_p;
    bit            m_hs;
    bit            m_pop;

    task automatic model_accept(input logic [RAW_W-1:0] v);
        logic [RAW_W-1:0] st;
        logic [AW-1:0]    a;
        st = stored_form(v, m_sat);
        for (int b = 0; b < m_p; b++) begin
            a = AW'(int'(m_base) + m_acc * m_p + b);
            exp_q.push_back({a, st[b*BW +: BW]});
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_state = 0; m_acc = 0; m_wr = 0; m_occ = 0; m_hb = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            check("busy", o_busy, m_state == 1);
            check("done", o_done, m_state == 2);
            check("overflow", o_overflow, m_ovf);
            check("wr_vld", o_wr_vld, m_occ > 0);
            case (m_state)
                0: if (start) begin
                    m_num = int'(num); m_sat = sat; m_base = base;
                    m_acc = 0; m_wr = 0; m_occ = 0; m_hb = 0; m_ovf = 0;
                    m_state = (num == 0) ? 2 : 1;
                end
                1: begin
                    m_p   = m_sat ? P_RAW / 2 : P_RAW;
                    m_hs  = (m_occ > 0) && rdy;
                    m_pop = m_hs && (m_hb == m_p - 1);
                    if (vld && m_acc < m_num) begin
                        if (m_occ < FD || m_pop) begin
                            model_accept(vec);
                            m_acc++;
                            m_occ++;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                    if (m_hs) m_hb = m_pop ? 0 : m_hb + 1;
                    if (m_pop) begin
                        m_occ--;
                        m_wr++;
                        if (m_wr == m_num) m_state = 2;
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    bit            stall_prev = 0;
    logic [BW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic [AW+BW-1:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("hold_data", o_wr_data, prev_data);
                check("hold_addr", o_wr_addr, prev_addr);
            end
            if (o_wr_vld && rdy) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_addr", o_wr_addr, e[BW +: AW]);
                    check("beat_data", o_wr_data, e[BW-1:0]);
                end
                cap_data_q.push_back(o_wr_data);
                cap_addr_q.push_back(o_wr_addr);
                last_hs_cyc = cyc;
            end
            if (o_done) begin
                done_count++;
                done_cyc = cyc;
            end
            stall_prev = o_wr_vld && !rdy;
            prev_data  = o_wr_data;
            prev_addr  = o_wr_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_data_q.delete();
        cap_addr_q.delete();
        done_count = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input int n, input bit s);
        base = b; num = CW'(n); sat = s; start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [RAW_W-1:0] v);
        vec = v; vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    function automatic logic [RAW_W-1:0] rand_vec();
        logic [RAW_W-1:0] r;
        for (int k = 0; k < DC; k++) begin
            if ($urandom_range(0, 1) == 1) r[k*16 +: 16] = 16'($urandom);
            else                           r[k*16 +: 16] = 16'($urandom_range(0, 400) - 200);
        end
        return r;
    endfunction

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!o_done && n < budget) begin
            tick();
            n++;
        end
        check(name, o_done, 1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [RAW_W-1:0] v;
    logic [BW-1:0]    bexp;
    logic [7:0]       pat8 [4];
    int               bad;

    initial begin
        pat8[0] = 8'h7F; pat8[1] = 8'h80; pat8[2] = 8'h05; pat8[3] = 8'hFB;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_data", o_wr_data, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_wr_vld", o_wr_vld, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_overflow", o_overflow, 0);
        rst_n = 1'b1;
        tick();

        // Raw job: two ramp vectors, 8 beats from 0x0100
        clear_caps();
        rdy = 1'b1;
        pulse_start(16'h0100, 2, 0);
        for (int k = 0; k < DC; k++) v[k*16 +: 16] = 16'(k);
        send(v);
        for (int k = 0; k < DC; k++) v[k*16 +: 16] = 16'(16'h1000 + k);
        send(v);
        wait_done(100, "raw_done_seen");
        repeat (2) tick();
        for (int k = 0; k < 8; k++) bexp[k*16 +: 16] = 16'(k);
        check("raw_beats", cap_data_q.size(), 8);
        check("raw_first_beat", cap_data_q[0], bexp);
        check("raw_last_addr", cap_addr_q[7], 16'h0107);
        check("raw_done_once", done_count, 1);
        check("raw_done_timing", done_cyc, last_hs_cyc + 1);

        // Saturation job
        clear_caps();
        pulse_start(16'h0200, 1, 1);
        for (int k = 0; k < DC; k++) begin
            case (k % 4)
                0: v[k*16 +: 16] = 16'h0080;
                1: v[k*16 +: 16] = 16'hFF7F;
                2: v[k*16 +: 16] = 16'h0005;
                default: v[k*16 +: 16] = 16'hFFFB;
            endcase
        end
        send(v);
        wait_done(100, "sat_done_seen");
        repeat (2) tick();
        for (int k = 0; k < 16; k++) bexp[k*8 +: 8] = pat8[k % 4];
        check("sat_beats", cap_data_q.size(), 2);
        check("sat_beat0", cap_data_q[0], bexp);
        check("sat_beat1", cap_data_q[1], bexp);
        check("sat_addr0", cap_addr_q[0], 16'h0200);
        check("sat_addr1", cap_addr_q[1], 16'h0201);

        // Backpressure mid-vector
        clear_caps();
        pulse_start(16'h0300, 2, 0);
        send(rand_vec());
        send(rand_vec());
        tick();
        rdy = 1'b0;
        repeat (3) tick();
        rdy = 1'b1;
        wait_done(100, "bp_done_seen");
        repeat (2) tick();
        check("bp_beats", cap_data_q.size(), 8);
        bad = 0;
        for (int i = 0; i < cap_addr_q.size(); i++)
            if (cap_addr_q[i] != AW'(16'h0300 + i)) bad++;
        check("bp_addr_seq", bad, 0);

        // Overflow: sink stalled, 6 strobes into a 4-deep FIFO
        clear_caps();
        rdy = 1'b0;
        pulse_start(16'h0400, 6, 0);
        for (int i = 0; i < 6; i++) begin
            send(rand_vec());
            check("ovf_flag", o_overflow, i >= 4);
        end
        rdy = 1'b1;
        repeat (30) tick();
        check("ovf_beats_first", cap_data_q.size(), 16);
        check("ovf_still_busy", o_busy, 1);
        check("ovf_no_done", done_count, 0);
        send(rand_vec());
        send(rand_vec());
        wait_done(100, "ovf_done_seen");
        repeat (2) tick();
        check("ovf_beats_total", cap_data_q.size(), 24);

        // num = 0
        clear_caps();
        pulse_start(16'h0500, 0, 0);
        repeat (4) tick();
        check("zero_done_once", done_count, 1);
        check("zero_done_lat", (done_cyc - start_cyc) inside {1, 2}, 1);
        check("zero_no_beats", cap_data_q.size(), 0);

        // Address wrap
        clear_caps();
        pulse_start(16'hFFFE, 1, 0);
        send(rand_vec());
        wait_done(100, "wrap_done_seen");
        repeat (2) tick();
        check("wrap_addr0", cap_addr_q[0], 16'hFFFE);
        check("wrap_addr1", cap_addr_q[1], 16'hFFFF);
        check("wrap_addr2", cap_addr_q[2], 16'h0000);
        check("wrap_addr3", cap_addr_q[3], 16'h0001);

        // Strobe in IDLE is ignored
        clear_caps();
        send(rand_vec());
        repeat (3) tick();
        check("idle_no_beats", cap_data_q.size(), 0);
        check("idle_no_vld", o_wr_vld, 0);

        // Start during RUN is ignored
        clear_caps();
        rdy = 1'b0;
        pulse_start(16'h0600, 1, 0);
        tick();
        pulse_start(16'h0A00, 3, 1);
        send(rand_vec());
        rdy = 1'b1;
        wait_done(100, "rerun_done_seen");
        repeat (2) tick();
        check("rerun_beats", cap_data_q.size(), P_RAW);
        check("rerun_addr0", cap_addr_q[0], 16'h0600);

        // Reset mid-job with two vectors queued
        rdy = 1'b0;
        pulse_start(16'h0700, 4, 0);
        send(rand_vec());
        send(rand_vec());
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_data", o_wr_data, 0);
        check("mid_rst_wr_addr", o_wr_addr, 0);
        check("mid_rst_wr_vld", o_wr_vld, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_overflow", o_overflow, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        clear_caps();
        rdy = 1'b1;
        pulse_start(16'h0800, 1, 1);
        send(rand_vec());
        wait_done(100, "post_rst_done_seen");
        repeat (2) tick();
        check("post_rst_beats", cap_data_q.size(), P_RAW / 2);
        check("post_rst_addr0", cap_addr_q[0], 16'h0800);

        // Randomized jobs: random strobes, random sink stalls
        for (int j = 0; j < 8; j++) begin
            int n;
            pulse_start(AW'($urandom), int'($urandom_range(1, 6)), bit'($urandom_range(0, 1)));
            n = 0;
            while (!o_done && n < 3000) begin
                vld = ($urandom_range(0, 1) == 1);
                vec = rand_vec();
                rdy = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end
            vld = 1'b0;
            rdy = 1'b1;
            check("rand_done_seen", o_done, 1);
            repeat (2) tick();
        end

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
